fsm_pattern_tx: RTL and testbench

FSM_PATTERN_TX -- requirements
Module: fsm_pattern_tx

---
 rtl/fsm_pattern_tx.sv | 132 +++++++++++++
 tb/tb_fsm_pattern_tx.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_pattern_tx.sv
// Serial pattern transmitter: sends the low len bits of a captured pattern
// MSB-first, repeated reps+1 times with an optional idle gap between frames,
// then pulses done for one cycle. Intended to drive a sequence detector.
module fsm_pattern_tx #(
    parameter int unsigned MAXLEN = 8,
    parameter int unsigned GAPW   = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [MAXLEN-1:0] pattern_i,
    input  logic [3:0]        len_i,
    input  logic [3:0]        reps_i,
    input  logic [GAPW-1:0]   gap_i,
    output logic              out_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int unsigned IdxW   = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    // Largest length representable on the 4-bit len input after clamping.
    localparam logic [3:0]  LenMax = (MAXLEN > 15) ? 4'd15 : 4'(MAXLEN);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StDone} state_e;

    state_e              state_q, state_d;
    logic [MAXLEN-1:0]   pattern_q, pattern_d;
    logic [3:0]          len_q, len_d;
    logic [3:0]          reps_q, reps_d;
    logic [GAPW-1:0]     gap_q, gap_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [3:0]          rep_q, rep_d;
    logic [GAPW-1:0]     gcnt_q, gcnt_d;
    logic [3:0]          len_c;

    assign len_c = (len_i > LenMax) ? LenMax : len_i;

    // State and captured configuration; everything clears on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            pattern_q <= '0;
            len_q     <= '0;
            reps_q    <= '0;
            gap_q     <= '0;
            idx_q     <= '0;
            rep_q     <= '0;
            gcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            reps_q    <= reps_d;
            gap_q     <= gap_d;
            idx_q     <= idx_d;
            rep_q     <= rep_d;
            gcnt_q    <= gcnt_d;
        end
    end

    // Next-state logic: capture in idle, walk bits, count repeats and gap cycles.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        reps_d    = reps_q;
        gap_d     = gap_q;
        idx_d     = idx_q;
        rep_d     = rep_q;
        gcnt_d    = gcnt_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    pattern_d = pattern_i;
                    len_d     = len_c;
                    reps_d    = reps_i;
                    gap_d     = gap_i;
                    idx_d     = IdxW'(len_c - 4'd1);
                    rep_d     = '0;
                    gcnt_d    = '0;
                    state_d   = (len_c == 4'd0) ? StDone : StSend;
                end
            end
            StSend: begin
                if (idx_q == '0) begin
                    if (rep_q == reps_q) begin
                        state_d = StDone;
                    end else begin
                        rep_d = rep_q + 4'd1;
                        idx_d = IdxW'(len_q - 4'd1);
                        if (gap_q == '0) begin
                            state_d = StSend;
                        end else begin
                            // Loaded one short so the gap lasts exactly gap_q cycles.
                            gcnt_d  = gap_q - GAPW'(1);
                            state_d = StGap;
                        end
                    end
                end else begin
                    idx_d = idx_q - IdxW'(1);
                end
            end
            StGap: begin
                if (gcnt_q == '0) begin
                    state_d = StSend;
                end else begin
                    gcnt_d = gcnt_q - GAPW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Moore outputs decoded from state and captured registers only.
    always_comb begin
        out_o   = 1'b0;
        valid_o = 1'b0;
        busy_o  = (state_q != StIdle);
        done_o  = (state_q == StDone);
        if (state_q == StSend) begin
            out_o   = pattern_q[idx_q];
            valid_o = 1'b1;
        end
    end

endmodule

// File: tb/tb_fsm_pattern_tx.sv
// Self-checking bench for fsm_pattern_tx: directed vector table, hand-written
// reset / held-start sequences, and randomized transactions against a
// cycle-list reference model.
module tb_fsm_pattern_tx;

    localparam int unsigned MAXLEN = 8;
    localparam int unsigned GAPW   = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [MAXLEN-1:0] pattern;
    logic [3:0]        len;
    logic [3:0]        reps;
    logic [GAPW-1:0]   gap;
    logic              out, valid, busy, done;
    logic [3:0]        obs;

    assign obs = {out, valid, busy, done};

    fsm_pattern_tx #(
        .MAXLEN(MAXLEN),
        .GAPW  (GAPW)
    ) dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .start_i  (start),
        .pattern_i(pattern),
        .len_i    (len),
        .reps_i   (reps),
        .gap_i    (gap),
        .out_o    (out),
        .valid_o  (valid),
        .busy_o   (busy),
        .done_o   (done)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Expected {out, valid, busy, done} for each cycle of one transaction.
    logic [3:0] exp_q[$];

    logic [15:0] act_bits;
    int          act_n, act_busy, act_done;

    typedef struct {
        logic [7:0]      pat;
        logic [3:0]      len;
        logic [3:0]      reps;
        logic [GAPW-1:0] gap;
        logic [15:0]     bits;
        int              nbits;
        int              busy;
        bit              scr;
    } vec_t;

    vec_t vt[7];

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b (out,valid,busy,done)", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_err++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Reference: list of per-cycle outputs from the frame/repeat/gap rules.
    function automatic void build_exp(input logic [7:0] p, input logic [3:0] l,
                                      input logic [3:0] r, input logic [GAPW-1:0] g);
        int n;
        exp_q.delete();
        n = (int'(l) > int'(MAXLEN)) ? int'(MAXLEN) : int'(l);
        if (n != 0) begin
            for (int f = 0; f <= int'(r); f++) begin
                for (int b = n - 1; b >= 0; b--) exp_q.push_back({p[b], 3'b110});
                if (f < int'(r)) repeat (int'(g)) exp_q.push_back(4'b0010);
            end
        end
        exp_q.push_back(4'b0011);
    endfunction

    // Overlapping "101" occurrences in the last n bits (newest bit at LSB).
    function automatic int count101(input logic [15:0] bits, input int n);
        int c = 0;
        for (int i = 0; i + 2 < n; i++) if (bits[i+2 -: 3] == 3'b101) c++;
        return c;
    endfunction

    // Starts at a negedge in idle; ends at a negedge back in idle.
    task automatic run_txn(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                           input logic [GAPW-1:0] g, input bit scramble, input string tag);
        build_exp(p, l, r, g);
        pattern  = p;
        len      = l;
        reps     = r;
        gap      = g;
        start    = 1'b1;
        act_bits = '0;
        act_n    = 0;
        act_busy = 0;
        act_done = 0;
        @(negedge clk);
        foreach (exp_q[i]) begin
            check($sformatf("%s cyc%0d", tag, i), obs, exp_q[i]);
            if (valid) begin
                act_bits = {act_bits[14:0], out};
                act_n++;
            end
            if (busy) act_busy++;
            if (done) act_done++;
            if (scramble) begin
                start   = 1'($urandom);
                pattern = 8'($urandom);
                len     = 4'($urandom);
                reps    = 4'($urandom);
                gap     = GAPW'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, " idle"}, obs, 4'b0000);
        start = 1'b0;
    endtask

    initial begin
        vt[0] = '{8'h05, 4'd3,  4'd0,  4'd0,  16'h0005, 3,  4,  1'b0};
        vt[1] = '{8'h05, 4'd3,  4'd3,  4'd0,  16'h0B6D, 12, 13, 1'b0};
        vt[2] = '{8'h05, 4'd3,  4'd1,  4'd2,  16'h002D, 6,  9,  1'b0};
        vt[3] = '{8'h05, 4'd0,  4'd0,  4'd0,  16'h0000, 0,  1,  1'b0};
        vt[4] = '{8'hA5, 4'd12, 4'd0,  4'd0,  16'h00A5, 8,  9,  1'b1};
        vt[5] = '{8'hFF, 4'd1,  4'd1,  4'd15, 16'h0003, 2,  18, 1'b0};
        vt[6] = '{8'h01, 4'd1,  4'd15, 4'd0,  16'hFFFF, 16, 17, 1'b0};

        rst_n   = 1'b0;
        start   = 1'b0;
        pattern = '0;
        len     = '0;
        reps    = '0;
        gap     = '0;
        repeat (2) @(negedge clk);
        check("reset state", obs, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (vt[i]) begin
            run_txn(vt[i].pat, vt[i].len, vt[i].reps, vt[i].gap, vt[i].scr,
                    $sformatf("vec%0d", i));
            check_int($sformatf("vec%0d bits", i), int'(act_bits), int'(vt[i].bits));
            check_int($sformatf("vec%0d nvalid", i), act_n, vt[i].nbits);
            check_int($sformatf("vec%0d busy", i), act_busy, vt[i].busy);
            check_int($sformatf("vec%0d done", i), act_done, 1);
            check_int($sformatf("vec%0d detect101", i), count101(act_bits, act_n),
                      count101(vt[i].bits, vt[i].nbits));
        end

        // Asynchronous reset in the middle of a len=8 frame.
        pattern = 8'hFF;
        len     = 4'd8;
        reps    = 4'd0;
        gap     = '0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2;
        check("2nd send cycle", obs, 4'b1110);
        rst_n = 1'b0;
        #1;
        check("async reset", obs, 4'b0000);
        start = 1'b1;
        len   = 4'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("reset hold %0d", k), obs, 4'b0000);
        end
        start = 1'b0;
        rst_n = 1'b1;
        run_txn(8'h05, 4'd3, 4'd0, 4'd0, 1'b0, "post-reset");

        // Start held high restarts on every idle cycle.
        build_exp(8'h02, 4'd2, 4'd0, 4'd0);
        exp_q.push_back(4'b0000);
        pattern = 8'h02;
        len     = 4'd2;
        reps    = 4'd0;
        gap     = '0;
        start   = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            foreach (exp_q[i]) begin
                check($sformatf("held start %0d.%0d", k, i), obs, exp_q[i]);
                @(negedge clk);
            end
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("held start drain", obs, 4'b0000);

        // Randomized transactions, with inputs optionally scrambled mid-flight.
        for (int t = 0; t < 40; t++) begin
            logic [3:0]      rl, rr;
            logic [GAPW-1:0] rg;
            rl = 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
            rg = ($urandom_range(0, 7) == 0) ? GAPW'(15) : GAPW'($urandom_range(0, 3));
            run_txn(8'($urandom), rl, rr, rg, 1'($urandom), $sformatf("rnd%0d", t));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
